muldiv_unit: RTL



---
 rtl/muldiv_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muldiv_unit : iterative RV32M multiply/divide, one bit per cycle         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] c_MUL = 3'b000;
  localparam logic [2:0] c_DIV = 3'b100;
  localparam logic [2:0] c_REM = 3'b110;

  state_t      state_q, state_d;
  logic [2:0]  fn_q, fn_d;
  logic        sa_q, sa_d, sb_q, sb_d;
  logic [31:0] opr_q, opr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;

  logic        w_signed_a, w_signed_b, w_neg_a, w_neg_b;
  logic [31:0] w_mag_a, w_mag_b;
  logic        w_div0, w_ovf;
  logic [32:0] w_mul_sum;
  logic [32:0] w_div_sh, w_div_diff;
  logic        w_div_ok;
  logic [63:0] w_prod;
  logic [31:0] w_quo, w_rem;

  always_comb begin
    w_signed_a = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    w_signed_b = w_signed_a && (funct3 != 3'b010);
    w_neg_a    = w_signed_a && op_a[31];
    w_neg_b    = w_signed_b && op_b[31];
    w_mag_a    = w_neg_a ? (~op_a + 32'd1) : op_a;
    w_mag_b    = w_neg_b ? (~op_b + 32'd1) : op_b;
    w_div0     = (op_b == 32'd0);
    w_ovf      = w_signed_a && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
  end

  // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right.
  // Divide:   acc = {remainder, dividend->quotient}; shift left, trial subtract.
  always_comb begin
    w_mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opr_q} : 33'd0);
    w_div_sh   = {acc_q[63:32], acc_q[31]};
    w_div_diff = w_div_sh - {1'b0, opr_q};
    w_div_ok   = ~w_div_diff[32];
    w_prod     = (sa_q ^ sb_q) ? (~acc_q + 64'd1) : acc_q;
    w_quo      = ((fn_q == c_DIV) && (sa_q ^ sb_q)) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    w_rem      = ((fn_q == c_REM) && sa_q) ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
  end

  always_comb begin
    state_d  = state_q;
    fn_d     = fn_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    opr_d    = opr_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          fn_d  = funct3;
          sa_d  = w_neg_a;
          sb_d  = w_neg_b;
          cnt_d = 5'd0;
          if (funct3[2]) begin
            opr_d = w_mag_b;
            acc_d = {32'd0, w_mag_a};
          end else begin
            opr_d = w_mag_a;
            acc_d = {32'd0, w_mag_b};
          end
          if (funct3[2] && w_div0) begin
            result_d = funct3[1] ? op_a : 32'hFFFF_FFFF;
            state_d  = S_DONE;
          end else if (funct3[2] && w_ovf) begin
            result_d = funct3[1] ? 32'd0 : 32'h8000_0000;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (fn_q[2]) begin
          acc_d = {(w_div_ok ? w_div_diff[31:0] : w_div_sh[31:0]), acc_q[30:0], w_div_ok};
        end else begin
          acc_d = {w_mul_sum, acc_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (fn_q[2]) begin
          result_d = fn_q[1] ? w_rem : w_quo;
        end else begin
          result_d = (fn_q == c_MUL) ? w_prod[31:0] : w_prod[63:32];
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      fn_q     <= 3'd0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      opr_q    <= 32'd0;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      fn_q     <= fn_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      opr_q    <= opr_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule
`default_nettype wire
